// File: rtl/spi_wb_master.sv
// SPI-slave (mode 0) to 8-bit Wishbone-master bridge. Oversamples the SPI pins on clk and turns
// command/address/data frames into single Wishbone read or write cycles.
module spi_wb_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   input  logic       wb_ack_i,
   output logic       busy_o
);

   localparam logic [1:0] ST_CMD  = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic WB_IDLE = 1'b0;
   localparam logic WB_BUS  = 1'b1;

   logic [2:0]  r_sck_s;
   logic [2:0]  r_cs_s;
   logic [1:0]  r_mosi_s;
   logic [1:0]  r_state;
   logic [2:0]  r_bit;
   logic [6:0]  r_rx;
   logic [7:0]  r_tx;
   logic        r_miso;
   logic        r_we_frame;
   logic [7:0]  r_ptr;
   logic        r_wb_st;
   logic [7:0]  r_adr;
   logic [7:0]  r_dat;
   logic        r_we;
   logic [15:0] r_cnt;
   logic [7:0]  r_hold;
   logic        r_pend;
   logic        r_to;
   logic        r_ov;

   logic        w_sck_rise;
   logic        w_sck_fall;
   logic        w_cs_high;
   logic        w_cs_fall;
   logic        w_mosi;
   logic [7:0]  w_byte;
   logic        w_byte_end;
   logic [7:0]  w_status;
   logic        w_launch;
   logic        w_launch_we;
   logic [7:0]  w_launch_adr;
   logic        w_flag_clr;
   logic        w_ack;
   logic        w_abort;
   logic        w_ov_set;

   // Bit 2 of the SCK/CS chains is the edge-detect register behind the 2-flop synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_s  <= 3'b000;
         r_cs_s   <= 3'b111;
         r_mosi_s <= 2'b00;
      end else begin
         r_sck_s  <= {r_sck_s[1:0], spi_sck};
         r_cs_s   <= {r_cs_s[1:0], spi_cs_n};
         r_mosi_s <= {r_mosi_s[0], spi_mosi};
      end
   end

   assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
   assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
   assign w_cs_high  = r_cs_s[1];
   assign w_cs_fall  = r_cs_s[2] & ~r_cs_s[1];
   assign w_mosi     = r_mosi_s[1];
   assign w_byte     = {r_rx, w_mosi};
   assign w_byte_end = ~w_cs_high & w_sck_rise & (r_bit == 3'd7);
   assign w_status   = {6'b0, r_ov, r_to};

   always_comb begin
      w_launch     = 1'b0;
      w_launch_we  = r_we_frame;
      w_launch_adr = r_ptr;
      w_flag_clr   = 1'b0;
      if (w_byte_end) begin
         case (r_state)
            ST_CMD:  w_flag_clr = 1'b1;
            ST_ADDR: begin
               w_launch     = ~r_we_frame;
               w_launch_adr = w_byte;
            end
            ST_DATA: w_launch = 1'b1;
            default: ;
         endcase
      end
   end

   // Frame FSM: byte assembly, address pointer and MISO shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_CMD;
         r_bit      <= 3'd0;
         r_rx       <= 7'd0;
         r_tx       <= 8'd0;
         r_miso     <= 1'b0;
         r_we_frame <= 1'b0;
         r_ptr      <= 8'd0;
      end else if (w_cs_high) begin
         r_state <= ST_CMD;
         r_bit   <= 3'd0;
         r_rx    <= 7'd0;
         r_tx    <= 8'd0;
         r_miso  <= 1'b0;
      end else if (w_cs_fall) begin
         r_state <= ST_CMD;
         r_bit   <= 3'd0;
         r_rx    <= 7'd0;
         r_tx    <= {w_status[6:0], 1'b0};
         r_miso  <= w_status[7];
      end else begin
         if (w_sck_rise) begin
            r_rx  <= w_byte[6:0];
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
               case (r_state)
                  ST_CMD: begin
                     r_we_frame <= w_byte[7];
                     r_state    <= ST_ADDR;
                     r_tx       <= 8'd0;
                  end
                  ST_ADDR: begin
                     r_ptr   <= w_byte + {7'd0, ~r_we_frame};
                     r_state <= ST_DATA;
                     r_tx    <= 8'd0;
                  end
                  ST_DATA: begin
                     r_ptr <= r_ptr + 8'd1;
                     r_tx  <= r_we_frame ? 8'd0 : r_hold;
                  end
                  default: r_state <= ST_CMD;
               endcase
            end
         end
         if (w_sck_fall) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
         end
      end
   end

   assign w_ack    = (r_wb_st == WB_BUS) & wb_ack_i;
   assign w_abort  = (r_wb_st == WB_BUS) & ~wb_ack_i & (r_cnt == 16'(TIMEOUT - 1));
   assign w_ov_set = w_launch & (r_wb_st == WB_BUS);

   // Wishbone FSM; r_pend marks a read whose result still belongs to the current frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_st <= WB_IDLE;
         r_adr   <= 8'd0;
         r_dat   <= 8'd0;
         r_we    <= 1'b0;
         r_cnt   <= 16'd0;
         r_hold  <= 8'd0;
         r_pend  <= 1'b0;
      end else begin
         case (r_wb_st)
            WB_IDLE: begin
               if (w_launch) begin
                  r_wb_st <= WB_BUS;
                  r_adr   <= w_launch_adr;
                  r_dat   <= w_byte;
                  r_we    <= w_launch_we;
                  r_cnt   <= 16'd0;
                  r_pend  <= ~w_launch_we;
               end
            end
            WB_BUS: begin
               if (w_ack) begin
                  r_wb_st <= WB_IDLE;
                  if (!r_we && r_pend) r_hold <= wb_dat_i;
                  r_pend <= 1'b0;
               end else if (w_abort) begin
                  r_wb_st <= WB_IDLE;
                  if (!r_we && r_pend) r_hold <= 8'hFF;
                  r_pend <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_wb_st <= WB_IDLE;
         endcase
         if (w_ov_set && !w_launch_we) begin
            r_hold <= 8'hFF;
            r_pend <= 1'b0;
         end
         if (w_cs_high) r_pend <= 1'b0;
      end
   end

   // Sticky status; a flag raised in the clearing cycle survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to <= 1'b0;
         r_ov <= 1'b0;
      end else begin
         r_to <= (r_to & ~w_flag_clr) | w_abort;
         r_ov <= (r_ov & ~w_flag_clr) | w_ov_set;
      end
   end

   assign spi_miso = r_miso & ~w_cs_high;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;
   assign wb_we_o  = r_we;
   assign wb_cyc_o = (r_wb_st == WB_BUS);
   assign wb_stb_o = (r_wb_st == WB_BUS);
   assign busy_o   = (r_wb_st == WB_BUS);

endmodule

// File: tb/tb_spi_wb_master.sv
// Directed bench for spi_wb_master: instance A has an acking slave, instance B (TIMEOUT=20)
// has a slave that never acks.
module tb_spi_wb_master;

   localparam int H = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sck = 1'b0, mosi = 1'b0, cs_a = 1'b1, cs_b = 1'b1, sel_b = 1'b0;

   logic       miso_a, we_a, cyc_a, stb_a, busy_a;
   logic       ack_a = 1'b0;
   logic [7:0] adr_a, dato_a, dati_a;
   logic       miso_b, we_b, cyc_b, stb_b, busy_b;
   logic       ack_b;
   logic [7:0] adr_b, dato_b, dati_b;

   assign dati_a = adr_a ^ 8'hA5;
   assign dati_b = 8'h00;
   assign ack_b  = 1'b0;

   spi_wb_master u_dut_a (
      .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_a), .spi_mosi(mosi),
      .spi_miso(miso_a), .wb_adr_o(adr_a), .wb_dat_o(dato_a), .wb_dat_i(dati_a),
      .wb_we_o(we_a), .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_ack_i(ack_a), .busy_o(busy_a)
   );

   spi_wb_master #(.TIMEOUT(20)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_b), .spi_mosi(mosi),
      .spi_miso(miso_b), .wb_adr_o(adr_b), .wb_dat_o(dato_b), .wb_dat_i(dati_b),
      .wb_we_o(we_b), .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_ack_i(ack_b), .busy_o(busy_b)
   );

   // Registered-ack slave for A; ack_delay=1 acks on the clk after stb is seen.
   int ack_delay = 1;
   int scnt = 0;
   always @(posedge clk) begin
      if (!cyc_a) begin
         ack_a <= 1'b0;
         scnt  <= 0;
      end else if (ack_a) begin
         ack_a <= 1'b0;
      end else begin
         if (scnt == ack_delay - 1) ack_a <= 1'b1;
         scnt <= scnt + 1;
      end
   end

   int         loga_n = 0, cura = 0;
   logic       preva = 1'b0;
   logic [7:0] loga_adr [64];
   logic [7:0] loga_dat [64];
   logic       loga_we  [64];
   int         loga_len [64];
   always @(negedge clk) begin
      preva <= cyc_a;
      if (cyc_a && !preva) begin
         loga_adr[loga_n] <= adr_a;
         loga_dat[loga_n] <= dato_a;
         loga_we[loga_n]  <= we_a;
         loga_n <= loga_n + 1;
         cura   <= 1;
      end else if (cyc_a) begin
         cura <= cura + 1;
      end else if (preva) begin
         loga_len[loga_n - 1] <= cura;
      end
   end

   int         logb_n = 0, curb = 0;
   logic       prevb = 1'b0;
   logic [7:0] logb_adr [64];
   int         logb_len [64];
   always @(negedge clk) begin
      prevb <= cyc_b;
      if (cyc_b && !prevb) begin
         logb_adr[logb_n] <= adr_b;
         logb_n <= logb_n + 1;
         curb   <= 1;
      end else if (cyc_b) begin
         curb <= curb + 1;
      end else if (prevb) begin
         logb_len[logb_n - 1] <= curb;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         wait_clk(H);
         rx = {rx[6:0], (sel_b ? miso_b : miso_a)};
         sck = 1'b1;
         wait_clk(H);
         sck = 1'b0;
      end
   endtask

   task automatic run_frame(input logic use_b, input logic [39:0] tx, input int nb,
                            output logic [39:0] rx);
      logic [7:0] b;
      sel_b = use_b;
      if (use_b) cs_b = 1'b0;
      else cs_a = 1'b0;
      rx = '0;
      for (int i = 0; i < nb; i++) begin
         spi_xfer(tx[39-8*i -: 8], 8, b);
         rx[39-8*i -: 8] = b;
      end
      wait_clk(H);
      cs_a = 1'b1;
      cs_b = 1'b1;
      wait_clk(40);
   endtask

   typedef struct {
      logic [39:0] tx;
      int          nb;
      logic [39:0] miso;
      logic [4:0]  care;
      int          ncyc;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  we;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vector(input int v);
      logic [39:0] rx;
      int base, got;
      base = loga_n;
      run_frame(1'b0, vecs[v].tx, vecs[v].nb, rx);
      got = loga_n - base;
      check($sformatf("v%0d_ncyc", v), got, vecs[v].ncyc);
      for (int j = 0; j < vecs[v].ncyc && j < got; j++) begin
         check($sformatf("v%0d_adr%0d", v, j), loga_adr[base+j], vecs[v].adr[31-8*j -: 8]);
         check($sformatf("v%0d_we%0d", v, j), loga_we[base+j], vecs[v].we[3-j]);
         if (vecs[v].we[3-j])
            check($sformatf("v%0d_dat%0d", v, j), loga_dat[base+j], vecs[v].dat[31-8*j -: 8]);
         check($sformatf("v%0d_len%0d", v, j), loga_len[base+j], 2);
      end
      for (int i = 0; i < vecs[v].nb; i++)
         if (vecs[v].care[4-i])
            check($sformatf("v%0d_miso%0d", v, i), rx[39-8*i -: 8], vecs[v].miso[39-8*i -: 8]);
   endtask

   initial begin
      logic [39:0] rx;
      logic [7:0]  b;
      int          base, k;

      vecs[0] = '{40'h80053C0000, 3, 40'h0, 5'b10000, 1, 32'h05000000, 32'h3C000000, 4'b1000};
      vecs[1] = '{40'h001B000000, 5, 40'h000000BEB9, 5'b10111, 4, 32'h1B1C1D1E, 32'h0, 4'b0000};
      vecs[2] = '{40'h80FE112233, 5, 40'h0, 5'b10000, 3, 32'hFEFF0000, 32'h11223300, 4'b1110};
      vecs[3] = '{40'h807FA00000, 3, 40'h0, 5'b10000, 1, 32'h7F000000, 32'hA0000000, 4'b1000};
      vecs[4] = '{40'h0042000000, 4, 40'h00000000E7, 5'b10110, 3, 32'h42434400, 32'h0, 4'b0000};
      vecs[4].miso = 40'h00000000E7 << 8;
      vecs[5] = '{40'h80335A0000, 3, 40'h0, 5'b10000, 1, 32'h33000000, 32'h5A000000, 4'b1000};

      wait_clk(3);
      check("rst_miso", miso_a, 0);
      check("rst_adr", adr_a, 0);
      check("rst_dat", dato_a, 0);
      check("rst_we", we_a, 0);
      check("rst_cyc", cyc_a, 0);
      check("rst_stb", stb_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_cyc_b", cyc_b, 0);
      rst_n = 1'b1;
      wait_clk(5);

      for (int v = 0; v < 5; v++) run_vector(v);

      // Timeout on B: every read expires after 20 clk and returns 0xFF.
      base = logb_n;
      run_frame(1'b1, 40'h0007000000, 4, rx);
      check("to_ncyc", logb_n - base, 3);
      check("to_adr0", logb_adr[base], 8'h07);
      check("to_len0", logb_len[base], 20);
      check("to_len1", logb_len[base+1], 20);
      check("to_miso_ff", rx[15:8], 8'hFF);
      check("to_miso_turn", rx[23:16], 8'h00);
      run_frame(1'b1, 40'h0, 1, rx);
      check("to_status1", rx[39:32], 8'h01);
      run_frame(1'b1, 40'h0, 1, rx);
      check("to_status2", rx[39:32], 8'h00);

      // Overrun on A: slow ack makes the second write collide.
      ack_delay = 200;
      base = loga_n;
      run_frame(1'b0, 40'h8040010200, 4, rx);
      wait_clk(250);
      check("ov_ncyc", loga_n - base, 1);
      check("ov_adr", loga_adr[base], 8'h40);
      check("ov_dat", loga_dat[base], 8'h01);
      ack_delay = 1;
      run_frame(1'b0, 40'h0, 1, rx);
      check("ov_status1", rx[39:32], 8'h02);
      run_frame(1'b0, 40'h0, 1, rx);
      check("ov_status2", rx[39:32], 8'h00);

      // Frame cut after half the address byte.
      base = loga_n;
      sel_b = 1'b0;
      cs_a = 1'b0;
      spi_xfer(8'h80, 8, b);
      spi_xfer(8'h33, 4, b);
      wait_clk(H);
      cs_a = 1'b1;
      wait_clk(40);
      check("abort_ncyc", loga_n - base, 0);
      run_vector(5);

      // Asynchronous reset while B is mid-cycle.
      sel_b = 1'b1;
      cs_b = 1'b0;
      spi_xfer(8'h00, 8, b);
      spi_xfer(8'h10, 8, b);
      k = 0;
      while (!cyc_b && k < 50) begin
         wait_clk(1);
         k++;
      end
      check("mid_cyc_up", cyc_b, 1);
      check("mid_adr", adr_b, 8'h10);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_cyc", cyc_b, 0);
      check("ar_stb", stb_b, 0);
      check("ar_busy", busy_b, 0);
      check("ar_adr", adr_b, 0);
      check("ar_dat", dato_b, 0);
      check("ar_we", we_b, 0);
      check("ar_miso", miso_b, 0);
      cs_b = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_wb_master.md
# spi_wb_master

SPI-slave to Wishbone-master bridge: the host MCU clocks command/address/data bytes over SPI, and this block issues 8-bit Wishbone read/write cycles to the audio peripherals (SID, mixer, etc.) on the shared 8-bit register bus. It is the initiator end of the 8-bit Wishbone interface the peripheral wrappers implement. SPI pins are asynchronous to `clk` and are oversampled. `clk` must be at least 16× the `spi_sck` frequency.

## Interface
- `TIMEOUT`, default 255: clk cycles a Wishbone cycle may wait for `wb_ack_i` before it is aborted (range 1–65535).
- `clk` in 1: system clock; everything, including the Wishbone bus, runs on it.
- `rst_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `spi_sck` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `spi_cs_n` in 1: SPI chip select, active-low, asynchronous.
- `spi_mosi` in 1: SPI data in, MSB first.
- `spi_miso` out 1: SPI data out, MSB first; 0 while `spi_cs_n` (synced) is high.
- `wb_adr_o` out 8: Wishbone address.
- `wb_dat_o` out 8: Wishbone write data.
- `wb_dat_i` in 8: Wishbone read data.
- `wb_we_o` out 1: 1 = write cycle.
- `wb_cyc_o` out 1: cycle valid.
- `wb_stb_o` out 1: strobe; always equal to `wb_cyc_o`.
- `wb_ack_i` in 1: slave acknowledge.
- `busy_o` out 1: Wishbone cycle in progress.

## Operation
- **Synchronisers.** `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchroniser. SCK rise and fall are detected on the synced signals.
  - SCK rise: MOSI is sampled.
  - SCK fall: the next MISO bit is shifted out.
- **Frame FSM** (states `CMD`, `ADDR`, `DATA`).
  - Synced CS falling enters `CMD` with bit counter 0.
  - Synced CS high at any time returns to `CMD`, clears the bit counter and discards any partial byte.
- **`CMD` byte.** Bit 7 = write (1) or read (0); bits 6:0 ignored. MISO carries the status byte {6'b0, overrun, timeout}. At byte end, both sticky bits clear (a flag set in that same cycle wins) and the FSM goes to `ADDR`.
- **`ADDR` byte.** The received byte loads the address pointer A; the FSM goes to `DATA`.
  - If the frame is a read, a read of A is launched at byte end.
- **`DATA`, write frame.** Each completed byte n (n=0,1,…) launches a write of A+n with that byte.
- **`DATA`, read frame.**
  - Byte 0 is turnaround; MISO = 0x00.
  - At the end of each DATA byte, a read of the next address is launched: A+1, A+2, and so on.
  - DATA byte k≥1 shifts out the result of the read of A+(k−1). That result is held in a 1-deep holding register and loaded into the shift register at the end of byte k−1.
  - One extra read past the last consumed byte is issued at frame end. This is accepted behaviour.
- **Address pointer.** 8-bit, wraps 0xFF→0x00.
- **Wishbone FSM** (`IDLE`, `BUS`).
  - A launch in `IDLE` drives `adr`/`dat`/`we`, sets `cyc`=`stb`=1 and enters `BUS`. `adr`, `dat_o` and `we` are stable for the whole of `BUS`.
  - `BUS` → `IDLE` on the edge where `wb_ack_i`=1 is sampled: `cyc`/`stb` drop, and for a read `wb_dat_i` is captured into the holding register.
  - Timeout counter reaching `TIMEOUT` in `BUS`: abort (drop `cyc`/`stb`), read result = 0xFF, set the sticky `timeout` flag.
  - A launch while in `BUS` is dropped: no cycle is issued, the sticky `overrun` flag is set, and a read result becomes 0xFF.
- **CS deassert during `BUS`.** The cycle runs to ack or timeout and is not aborted. A pending read result is discarded.
- **Asynchronous reset.** Drives all outputs to 0, the FSMs to `CMD`/`IDLE`, and flags, pointer, counters and shift registers to 0.

## Timing
- **Reset values:** `spi_miso`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_we_o`=0, `wb_cyc_o`=0, `wb_stb_o`=0, `busy_o`=0.
- **SCK to internal edge:** 3 clk from a pin SCK edge to the detected edge (2 sync + 1 edge register).
- **Launch:** `cyc`/`stb` rise 1 clk after the clk in which the 8th SCK rise of a byte is detected.
- **Registered-ack slave:** `cyc`/`stb` are high for exactly 2 clk per cycle.
- **Timeout count:** `cyc` is high for exactly `TIMEOUT` clk when no ack arrives.
- **MISO:** a new bit is valid on `spi_miso` 1 clk after the detected SCK fall. The first bit of the `CMD` byte is valid 1 clk after the detected CS fall.
- **Ack and timeout in the same clk:** the ack wins, so data is captured and `timeout` is not set.
- **`busy_o`:** equals `wb_cyc_o`.

## Test plan
- **Single write.** Frame 0x80,0x05,0x3C with a slave acking 1 clk after `stb` → exactly one cycle: `adr`=0x05, `dat`=0x3C, `we`=1, `cyc` high 2 clk; `CMD` MISO byte = 0x00.
- **Burst read.** Frame 0x00,0x1B,xx,xx,xx with slave data = adr^0xA5 → reads of 0x1B, 0x1C, 0x1D, 0x1E issued in order; MISO DATA bytes = 0x00, 0xBE, 0xB9.
- **Burst write wrap.** Frame 0x80,0xFE,0x11,0x22,0x33 → writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
- **Timeout.** Slave never acks, `TIMEOUT`=20, read frame at 0x07 → `cyc` high 20 clk then low; MISO returns 0xFF. The next frame's status byte = 0x01, and the following frame's status byte = 0x00.
- **Overrun.** Slave delays ack longer than one SPI byte during a burst write → the dropped write is not issued; the next status byte = 0x02.
- **Aborted frame and reset.**
  - CS raised after 4 bits of the `ADDR` byte → no Wishbone cycle; the next full frame behaves normally.
  - `rst_n` low mid-`BUS` → all outputs 0 within the same clk, with no clock edge required.
